// File: rtl/mem_access_unit_if.sv
// Data-cache controller handshake bus: start/we/byte/addr/write lanes out, read lanes and ready back.
// master = MEM-stage front end (mem_access_unit), slave = cache controller.
interface mem_access_unit_if;
   logic            cc_enable;
   logic            cc_we;
   logic            cc_is_byte;
   logic [31:0]     cc_addr;
   logic [3:0][7:0] cc_data_in;
   logic [3:0][7:0] cc_data_out;
   logic            cc_ready;

   modport master (
      output cc_enable,
      output cc_we,
      output cc_is_byte,
      output cc_addr,
      output cc_data_in,
      input  cc_data_out,
      input  cc_ready
   );

   modport slave (
      input  cc_enable,
      input  cc_we,
      input  cc_is_byte,
      input  cc_addr,
      input  cc_data_in,
      output cc_data_out,
      output cc_ready
   );
endinterface

// File: rtl/mem_access_unit.sv
// MIPS MEM-stage front end: turns lw/sw/lb/lbu/sb into a cache-controller transaction and stalls until done.
// Optional feature: define MEM_TIMEOUT_EN to abort a WAIT that exceeds TIMEOUT_CYCLES (raises timeout_err).
module mem_access_unit #(
   parameter int QUIESCE_CYCLES = 16,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic              req_byte,
   input  logic              req_unsigned,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              stall,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              misalign_err,
   output logic              timeout_err,
   mem_access_unit_if.master cc
);

   typedef enum logic [2:0] {
      S_QUIESCE,
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_DONE
   } state_t;

   // One counter serves the post-reset drain and, when enabled, the WAIT timeout.
   localparam int CNT_MAX = (QUIESCE_CYCLES > TIMEOUT_CYCLES) ? QUIESCE_CYCLES : TIMEOUT_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] Q_LAST = CNT_W'(QUIESCE_CYCLES - 1);
`ifdef MEM_TIMEOUT_EN
   localparam logic [CNT_W-1:0] T_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             ld_unsigned;
   logic             aligned;

   // Byte ops may target any lane; word ops must sit on a 4-byte boundary.
   assign aligned = req_byte | (req_addr[1:0] == 2'b00);

   // Big-endian lane order: lane 3 is the most significant byte of the word.
   function automatic logic [31:0] format_load(input logic            we,
                                               input logic            is_byte,
                                               input logic            uns,
                                               input logic [3:0][7:0] d);
      logic [31:0] r;
      if (we)
         r = 32'h0;
      else if (is_byte && uns)
         r = {24'h0, d[0]};
      else
         r = {d[3], d[2], d[1], d[0]};
      return r;
   endfunction

   // NOTE: every output of an always_comb gets a default first, otherwise a path that skips it infers a latch.
   always_comb begin
      stall        = 1'b0;
      misalign_err = 1'b0;
      case (state)
         S_QUIESCE: stall = req_valid;
         S_IDLE: begin
            stall        = req_valid & aligned;
            misalign_err = req_valid & ~aligned;
         end
         S_ISSUE,
         S_WAIT:    stall = 1'b1;
         default:   stall = 1'b0;
      endcase
   end

   // NOTE: state and outputs are registers, so they are written with non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_QUIESCE;
         cnt           <= '0;
         ld_unsigned   <= 1'b0;
         resp_valid    <= 1'b0;
         resp_rdata    <= 32'h0;
         timeout_err   <= 1'b0;
         cc.cc_enable  <= 1'b0;
         cc.cc_we      <= 1'b0;
         cc.cc_is_byte <= 1'b0;
         cc.cc_addr    <= 32'h0;
         cc.cc_data_in <= '0;
      end else begin
         case (state)
            // A controller ready pulse left over from an aborted transaction lands here and is dropped.
            S_QUIESCE: begin
               if (cnt == Q_LAST) begin
                  cnt   <= '0;
                  state <= S_IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            S_IDLE: begin
               if (req_valid && aligned) begin
                  cc.cc_we      <= req_we;
                  cc.cc_is_byte <= req_byte;
                  cc.cc_addr    <= req_addr;
                  cc.cc_data_in <= req_byte ? {24'h0, req_wdata[7:0]} : req_wdata;
                  ld_unsigned   <= req_byte & req_unsigned;
                  cc.cc_enable  <= 1'b1;
                  state         <= S_ISSUE;
               end
            end

            S_ISSUE: begin
               cc.cc_enable <= 1'b0;
               cnt          <= '0;
               state        <= S_WAIT;
            end

            S_WAIT: begin
               if (cc.cc_ready) begin
                  resp_rdata <= format_load(cc.cc_we, cc.cc_is_byte, ld_unsigned, cc.cc_data_out);
                  resp_valid <= 1'b1;
                  state      <= S_DONE;
               end
`ifdef MEM_TIMEOUT_EN
               else if (cnt == T_LAST) begin
                  resp_rdata  <= 32'h0;
                  resp_valid  <= 1'b1;
                  timeout_err <= 1'b1;
                  state       <= S_DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
`endif
            end

            // The pipeline advances during this cycle, so the request still on the inputs is already retired.
            S_DONE: begin
               resp_valid  <= 1'b0;
               timeout_err <= 1'b0;
               state       <= S_IDLE;
            end

            default: state <= S_QUIESCE;
         endcase
      end
   end

endmodule
